// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown of outstanding writes,
// flagging RAW/WAW hazards for the ID instruction and driving stall.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_ADDR = 5,
    parameter int LAT_W    = 3,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid_i,
    input  logic [REG_ADDR-1:0] id_rs1_i,
    input  logic                id_rs1_used_i,
    input  logic [REG_ADDR-1:0] id_rs2_i,
    input  logic                id_rs2_used_i,
    input  logic [REG_ADDR-1:0] id_rd_i,
    input  logic                id_rd_we_i,
    input  logic [LAT_W-1:0]    id_lat_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                issue_o,
    output logic                hazard_raw_o,
    output logic                hazard_waw_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    logic [LAT_W-1:0] r_cnt [1:NUM_REGS-1];
    logic [LAT_W-1:0] w_cnt [NUM_REGS];
    logic [CNT_W-1:0] r_stall_cnt;
    logic [LAT_W-1:0] w_lat_eff;
    logic             w_raw;
    logic             w_waw;
    logic             w_stall;
    logic             w_issue;

    function automatic logic f_ready(input logic [LAT_W-1:0] c);
        return (c == '0) || ((BYPASS != 0) && (c == LAT_W'(1)));
    endfunction

    // Register 0 never holds a pending write.
    always_comb begin
        w_cnt[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) w_cnt[i] = r_cnt[i];
    end

    assign w_lat_eff = (id_lat_i == '0) ? LAT_W'(1) : id_lat_i;

    assign w_raw = id_valid_i &
                   ((id_rs1_used_i & !f_ready(w_cnt[id_rs1_i])) |
                    (id_rs2_used_i & !f_ready(w_cnt[id_rs2_i])));

    // New write must retire strictly after the pending one.
    assign w_waw = id_valid_i & id_rd_we_i & (id_rd_i != '0) &
                   (w_cnt[id_rd_i] >= w_lat_eff);

    assign w_stall = rst_n & (w_raw | w_waw) & !flush_i;
    assign w_issue = rst_n & id_valid_i & !w_stall & !flush_i;

    assign stall_o      = w_stall;
    assign issue_o      = w_issue;
    assign hazard_raw_o = rst_n & w_raw & !flush_i;
    assign hazard_waw_o = rst_n & w_waw & !flush_i;
    assign stall_cnt_o  = r_stall_cnt;

    always_comb begin
        busy_o = '0;
        for (int i = 1; i < NUM_REGS; i++) busy_o[i] = (r_cnt[i] != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) r_cnt[i] <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_issue && id_rd_we_i && (id_rd_i == REG_ADDR'(i)))
                    r_cnt[i] <= w_lat_eff;
                else if (r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - LAT_W'(1);
            end
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of three scoreboard builds
// (bypass, no bypass, 4-bit stall counter) sharing one ID stream.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, rs1u, rs2u, rdwe, flush;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] lat;

    logic        s1, i1, h1r, h1w;
    logic        s0, i0, h0r, h0w;
    logic        sc, ic, hcr, hcw;
    logic [31:0] b1, b0, bc;
    logic [15:0] c1, c0;
    logic [3:0]  c4;

    int n_cmp = 0;
    int n_bad = 0;
    int chain_cyc [3];

    always #5 clk = ~clk;

    hazard_scoreboard #(.BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(valid),
        .id_rs1_i(rs1), .id_rs1_used_i(rs1u),
        .id_rs2_i(rs2), .id_rs2_used_i(rs2u),
        .id_rd_i(rd), .id_rd_we_i(rdwe), .id_lat_i(lat),
        .flush_i(flush), .stall_o(s1), .issue_o(i1),
        .hazard_raw_o(h1r), .hazard_waw_o(h1w),
        .busy_o(b1), .stall_cnt_o(c1)
    );

    hazard_scoreboard #(.BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(valid),
        .id_rs1_i(rs1), .id_rs1_used_i(rs1u),
        .id_rs2_i(rs2), .id_rs2_used_i(rs2u),
        .id_rd_i(rd), .id_rd_we_i(rdwe), .id_lat_i(lat),
        .flush_i(flush), .stall_o(s0), .issue_o(i0),
        .hazard_raw_o(h0r), .hazard_waw_o(h0w),
        .busy_o(b0), .stall_cnt_o(c0)
    );

    hazard_scoreboard #(.BYPASS(1), .CNT_W(4)) dutc (
        .clk(clk), .rst_n(rst_n), .id_valid_i(valid),
        .id_rs1_i(rs1), .id_rs1_used_i(rs1u),
        .id_rs2_i(rs2), .id_rs2_used_i(rs2u),
        .id_rd_i(rd), .id_rd_we_i(rdwe), .id_lat_i(lat),
        .flush_i(flush), .stall_o(sc), .issue_o(ic),
        .hazard_raw_o(hcr), .hazard_waw_o(hcw),
        .busy_o(bc), .stall_cnt_o(c4)
    );

    task automatic idle();
        valid = 0; rs1u = 0; rs2u = 0; rdwe = 0; flush = 0;
        rs1 = 0; rs2 = 0; rd = 0; lat = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        tick();
        valid = 1; rd = 5; rdwe = 1; lat = 3;
        #1;
        n_cmp++;
        if ({s1, i1, h1r, h1w} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outs: got %b exp 0000", {s1, i1, h1r, h1w});
        end
        n_cmp++;
        if (b1 !== 32'h0 || c1 !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state: busy %h cnt %0d exp 0/0", b1, c1);
        end
        rst_n = 1;
    endtask

    task automatic test_raw();
        do_reset();
        valid = 1; rd = 5; rdwe = 1; lat = 3;
        #1;
        n_cmp++;
        if ({i1, i0} !== 2'b11) begin
            n_bad++;
            $display("FAIL raw_producer_issue: got %b exp 11", {i1, i0});
        end
        tick();
        idle();
        valid = 1; rs1 = 5; rs1u = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if ({s1, i1, h1r, h1w} !== ((k < 2) ? 4'b1010 : 4'b0100)) begin
                n_bad++;
                $display("FAIL raw_byp1 cyc%0d: got %b", k, {s1, i1, h1r, h1w});
            end
            n_cmp++;
            if ({s0, i0, h0r, h0w} !== ((k < 3) ? 4'b1010 : 4'b0100)) begin
                n_bad++;
                $display("FAIL raw_byp0 cyc%0d: got %b", k, {s0, i0, h0r, h0w});
            end
            tick();
        end
        idle();
        #1;
        n_cmp++;
        if (c1 !== 16'd2 || c0 !== 16'd3 || c4 !== 4'd2) begin
            n_bad++;
            $display("FAIL raw_stall_cnt: got %0d/%0d/%0d exp 2/3/2", c1, c0, c4);
        end
    endtask

    task automatic test_waw();
        do_reset();
        valid = 1; rd = 7; rdwe = 1; lat = 4;
        tick();
        lat = 2;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if ({s1, i1, h1r, h1w, b1[7]} !== ((k < 3) ? 5'b10011 : 5'b01001)) begin
                n_bad++;
                $display("FAIL waw cyc%0d: got %b", k, {s1, i1, h1r, h1w, b1[7]});
            end
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (b1[7] !== ((k < 2) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL waw_reload cyc%0d: got %b", k, b1[7]);
            end
            tick();
        end
    endtask

    task automatic test_zero();
        do_reset();
        valid = 1; rs1 = 0; rs1u = 1; rd = 0; rdwe = 1; lat = 7;
        #1;
        n_cmp++;
        if ({s1, i1, h1r, h1w} !== 4'b0100) begin
            n_bad++;
            $display("FAIL zero_issue: got %b exp 0100", {s1, i1, h1r, h1w});
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (b1 !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_busy: got %h exp 0", b1);
        end
        valid = 1; rd = 3; rdwe = 1; lat = 0;
        tick();
        idle();
        #1;
        n_cmp++;
        if (b1 !== 32'h8) begin
            n_bad++;
            $display("FAIL lat0_busy_on: got %h exp 8", b1);
        end
        tick();
        n_cmp++;
        if (b1[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL lat0_busy_off: got %b exp 0", b1[3]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        valid = 1; rd = 5; rdwe = 1; lat = 4;
        tick();
        idle();
        valid = 1; rs1 = 5; rs1u = 1; rd = 6; rdwe = 1; lat = 2; flush = 1;
        #1;
        n_cmp++;
        if ({s1, i1, h1r, h1w, s0, i0} !== 6'b0) begin
            n_bad++;
            $display("FAIL flush_outs: got %b exp 000000", {s1, i1, h1r, h1w, s0, i0});
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (b1 !== 32'h20) begin
            n_bad++;
            $display("FAIL flush_busy: got %h exp 00000020", b1);
        end
        valid = 1; rs1 = 5; rs1u = 1;
        #1;
        n_cmp++;
        if ({s1, i1, h1r, h1w} !== 4'b1010) begin
            n_bad++;
            $display("FAIL flush_kept_cnt: got %b exp 1010", {s1, i1, h1r, h1w});
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (c1 !== 16'd1) begin
            n_bad++;
            $display("FAIL flush_stall_cnt: got %0d exp 1", c1);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int b = 0; b < 4; b++) begin
            idle();
            valid = 1; rd = 9; rdwe = 1; lat = 7;
            tick();
            idle();
            valid = 1; rs1 = 9; rs1u = 1;
            repeat (6) tick();
            if (b == 1) begin
                n_cmp++;
                if (c4 !== 4'd12) begin
                    n_bad++;
                    $display("FAIL sat_mid: got %0d exp 12", c4);
                end
            end
        end
        idle();
        #1;
        n_cmp++;
        if (c4 !== 4'd15 || c1 !== 16'd24) begin
            n_bad++;
            $display("FAIL sat_end: got %0d/%0d exp 15/24", c4, c1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 1; rd = 9; rdwe = 1; lat = 7;
        tick();
        idle();
        valid = 1; rs1 = 9; rs1u = 1;
        tick();
        tick();
        rst_n = 0;
        #1;
        n_cmp++;
        if ({s1, i1, h1r, h1w, s0, i0, sc, ic} !== 8'b0) begin
            n_bad++;
            $display("FAIL rstmid_outs: got %b exp 0", {s1, i1, h1r, h1w, s0, i0, sc, ic});
        end
        n_cmp++;
        if (b1 !== 32'h200) begin
            n_bad++;
            $display("FAIL rstmid_busy_pre: got %h exp 00000200", b1);
        end
        tick();
        n_cmp++;
        if (b1 !== 32'h0 || c1 !== 16'h0 || c4 !== 4'h0 || {s1, i1} !== 2'b00) begin
            n_bad++;
            $display("FAIL rstmid_post: busy %h cnt %0d/%0d si %b", b1, c1, c4, {s1, i1});
        end
        rst_n = 1;
        #1;
        n_cmp++;
        if ({s1, i1, h1r, h1w} !== 4'b0100) begin
            n_bad++;
            $display("FAIL rstmid_release: got %b exp 0100", {s1, i1, h1r, h1w});
        end
        tick();
        idle();
    endtask

    task automatic run_chain(input bit byp);
        int t;
        int n;
        t = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            valid = 1; rdwe = 1;
            rd = 5'(k + 1);
            lat = (k == 1) ? 3'd2 : 3'd1;
            rs1u = (k != 0);
            rs1 = 5'(k);
            #1;
            n = 0;
            while (!(byp ? i1 : i0) && n < 10) begin
                tick();
                #1;
                t++;
                n++;
            end
            if (n == 10) begin
                n_cmp++;
                n_bad++;
                $display("FAIL chain_timeout byp%0d inst%0d", byp, k);
            end
            chain_cyc[k] = t;
            tick();
            t++;
        end
        idle();
    endtask

    task automatic test_back_to_back();
        run_chain(1'b1);
        n_cmp++;
        if (chain_cyc[0] !== 0 || chain_cyc[1] !== 1 || chain_cyc[2] !== 3) begin
            n_bad++;
            $display("FAIL chain_byp1: got %0d,%0d,%0d exp 0,1,3",
                     chain_cyc[0], chain_cyc[1], chain_cyc[2]);
        end
        run_chain(1'b0);
        n_cmp++;
        if (chain_cyc[0] !== 0 || chain_cyc[1] !== 2 || chain_cyc[2] !== 5) begin
            n_bad++;
            $display("FAIL chain_byp0: got %0d,%0d,%0d exp 0,2,5",
                     chain_cyc[0], chain_cyc[1], chain_cyc[2]);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_raw();
        test_waw();
        test_zero();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
